// File: rtl/apb_master.sv
// APB initiator: one command in, one SETUP/ACCESS transfer, one response out.
// A bounded ACCESS wait counter aborts transfers to a stalled slave.
module apb_master #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  localparam int CNT_W =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t     state;
  logic [CNT_W-1:0] wait_cnt;
  logic       cnt_max;
  logic       tmo_hit;

  assign cnt_max = (wait_cnt == {CNT_W{1'b1}});
  assign tmo_hit = (TIMEOUT != 0) &&
                   (wait_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      paddr_o     <= '0;
      pwrite_o    <= 1'b0;
      pwdata_o    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            pwrite_o    <= cmd_write_i;
            paddr_o     <= cmd_addr_i;
            pwdata_o    <= cmd_wdata_i;
            psel_o      <= 1'b1;
            cmd_ready_o <= 1'b0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          wait_cnt  <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          // pready takes priority over an expiring timeout
          if (pready_i) begin
            rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            state       <= RESP;
          end else if (tmo_hit) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            state       <= RESP;
          end else if (!cnt_max) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
